// File: rtl/rstmgr_pwr_resp_pkg.sv
// Shared types for the reset-manager power-manager responder: cause and domain
// count come from the power manager, the per-domain state enum from the reset manager.
package pwrmgr_pkg;
    localparam int unsigned PowerDomains = 2;

    typedef enum logic [1:0] {
        ResetNone      = 2'd0,
        LowPwrEntry    = 2'd1,
        HwReq          = 2'd2,
        ResetUndefined = 2'd3
    } reset_cause_e;
endpackage

package rstmgr_pkg;
    typedef enum logic [2:0] {
        Asserted   = 3'd0,
        LcRelWait  = 3'd1,
        LcOn       = 3'd2,
        SysRelWait = 3'd3,
        Active     = 3'd4
    } rst_resp_state_e;
endpackage

// File: rtl/rstmgr_pwr_resp_if.sv
// Power-manager <-> reset-manager request/status bundle; master is the power
// manager side, slave is the reset-manager responder.
interface rstmgr_pwr_resp_if #(
    parameter int unsigned NumRstReqs = 2
) ();
    localparam int unsigned Doms = pwrmgr_pkg::PowerDomains;

    logic [Doms-1:0]           rst_lc_req_i;
    logic [Doms-1:0]           rst_sys_req_i;
    pwrmgr_pkg::reset_cause_e  reset_cause_i;
    logic [NumRstReqs-1:0]     rstreqs_i;
    logic                      info_clr_i;
    logic [Doms-1:0]           rst_lc_src_no;
    logic [Doms-1:0]           rst_sys_src_no;
    logic [NumRstReqs:0]       reset_info_o;
    logic                      reset_info_vld_o;
    logic                      err_o;

    modport master (
        output rst_lc_req_i, rst_sys_req_i, reset_cause_i, rstreqs_i, info_clr_i,
        input  rst_lc_src_no, rst_sys_src_no, reset_info_o, reset_info_vld_o, err_o
    );

    modport slave (
        input  rst_lc_req_i, rst_sys_req_i, reset_cause_i, rstreqs_i, info_clr_i,
        output rst_lc_src_no, rst_sys_src_no, reset_info_o, reset_info_vld_o, err_o
    );
endinterface

// File: rtl/rstmgr_pwr_resp_dom.sv
// One power domain: ordered, stretched LC-then-SYS release with immediate
// assertion; flags the events that should capture reset info.
module rstmgr_pwr_resp_dom
    import rstmgr_pkg::*;
#(
    parameter int unsigned StretchCycles = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lc_req,
    input  logic sys_req,
    output logic lc_src_n,
    output logic sys_src_n,
    output logic capture_c
);
    localparam int unsigned CntW = $clog2(StretchCycles + 1);

    rst_resp_state_e  state_q;
    logic [CntW-1:0]  cnt_q;
    logic             cnt_done_c;
    logic [CntW-1:0]  cnt_inc_c;

    assign cnt_done_c = (cnt_q == CntW'(StretchCycles - 1));
    assign cnt_inc_c  = (cnt_q == CntW'(StretchCycles)) ? cnt_q : cnt_q + CntW'(1);

    // Entry into Asserted, or a SYS-only re-assertion from a released SYS.
    assign capture_c = (lc_req && (state_q != Asserted)) ||
                       (!lc_req && sys_req && ((state_q == SysRelWait) || (state_q == Active)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= Asserted;
            cnt_q     <= '0;
            lc_src_n  <= 1'b0;
            sys_src_n <= 1'b0;
        end else if (lc_req) begin
            state_q   <= Asserted;
            cnt_q     <= '0;
            lc_src_n  <= 1'b0;
            sys_src_n <= 1'b0;
        end else begin
            case (state_q)
                Asserted: begin
                    state_q <= LcRelWait;
                    cnt_q   <= '0;
                end
                LcRelWait: begin
                    if (cnt_done_c) begin
                        state_q  <= LcOn;
                        cnt_q    <= '0;
                        lc_src_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                LcOn: begin
                    if (!sys_req) begin
                        state_q <= SysRelWait;
                        cnt_q   <= '0;
                    end
                end
                SysRelWait: begin
                    if (sys_req) begin
                        state_q   <= LcOn;
                        cnt_q     <= '0;
                        sys_src_n <= 1'b0;
                    end else if (cnt_done_c) begin
                        state_q   <= Active;
                        cnt_q     <= '0;
                        sys_src_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                Active: begin
                    if (sys_req) begin
                        state_q   <= LcOn;
                        cnt_q     <= '0;
                        sys_src_n <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= Asserted;
                    cnt_q     <= '0;
                    lc_src_n  <= 1'b0;
                    sys_src_n <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/rstmgr_pwr_resp.sv
// Reset-manager responder to power-manager reset requests: per-domain release
// sequencing, sticky protocol error, optional reset info (RSTMGR_PWR_RESP_INFO_EN).
module rstmgr_pwr_resp
    import pwrmgr_pkg::*;
    import rstmgr_pkg::*;
#(
    parameter int unsigned NumRstReqs    = 2,
    parameter int unsigned StretchCycles = 8
) (
    input logic                clk_i,
    input logic                rst_ni,
    rstmgr_pwr_resp_if.slave   bus
);
    localparam int unsigned Stretch = (StretchCycles < 1) ? 1 : StretchCycles;

    logic [PowerDomains-1:0] lc_src_n;
    logic [PowerDomains-1:0] sys_src_n;
    logic [PowerDomains-1:0] capture_c;
    logic                    err_q;

    for (genvar d = 0; d < int'(PowerDomains); d++) begin : g_dom
        rstmgr_pwr_resp_dom #(
            .StretchCycles (Stretch)
        ) u_dom (
            .clk       (clk_i),
            .rst_n     (rst_ni),
            .lc_req    (bus.rst_lc_req_i[d]),
            .sys_req   (bus.rst_sys_req_i[d]),
            .lc_src_n  (lc_src_n[d]),
            .sys_src_n (sys_src_n[d]),
            .capture_c (capture_c[d])
        );
    end

    assign bus.rst_lc_src_no  = lc_src_n;
    assign bus.rst_sys_src_no = sys_src_n;

    // SYS released while LC still requested is a protocol violation; sticky to reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|(bus.rst_lc_req_i & ~bus.rst_sys_req_i));
        end
    end

    assign bus.err_o = err_q;

`ifdef RSTMGR_PWR_RESP_INFO_EN
    logic [NumRstReqs:0] info_q;
    logic [NumRstReqs:0] cause_bits_c;
    logic [NumRstReqs:0] info_d_c;
    logic                vld_q;

    always_comb begin
        cause_bits_c = '0;
        case (bus.reset_cause_i)
            LowPwrEntry: cause_bits_c[0] = 1'b1;
            HwReq:       cause_bits_c    = {bus.rstreqs_i, 1'b0};
            default:     cause_bits_c    = '0;
        endcase
    end

    // A recording capture takes priority over a same-cycle clear.
    always_comb begin
        info_d_c = info_q;
        if ((|capture_c) && (|cause_bits_c)) begin
            info_d_c = info_q | cause_bits_c;
        end else if (bus.info_clr_i) begin
            info_d_c = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            info_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            info_q <= info_d_c;
            vld_q  <= |info_d_c;
        end
    end

    assign bus.reset_info_o     = info_q;
    assign bus.reset_info_vld_o = vld_q;
`else
    logic unused_info;

    assign unused_info          = ^{2'(bus.reset_cause_i), bus.rstreqs_i, bus.info_clr_i, capture_c};
    assign bus.reset_info_o     = '0;
    assign bus.reset_info_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_rstmgr_pwr_resp.sv
// Directed plus randomized bench for rstmgr_pwr_resp against a run-length
// reference model of the release/assert rules.
module tb_rstmgr_pwr_resp;
    import pwrmgr_pkg::*;

    localparam int S   = 8;
    localparam int SAT = S + 1;
    localparam int ND  = int'(PowerDomains);

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    int         lc_run  [ND];
    int         sys_run [ND];
    logic       err_m;
    logic [2:0] info_m;

    rstmgr_pwr_resp_if #(.NumRstReqs(2)) bus_if ();

    rstmgr_pwr_resp #(
        .NumRstReqs    (2),
        .StretchCycles (S)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            lc_run[d]  = 0;
            sys_run[d] = 0;
        end
        err_m  = 1'b0;
        info_m = 3'b000;
    endtask

    // Outputs released once the request has been low for SAT sampled edges.
    task automatic model_step();
        logic       cap;
        logic [2:0] bits;
        logic       lr, sr, prev_on;
        cap = 1'b0;
        for (int d = 0; d < ND; d++) begin
            lr      = bus_if.rst_lc_req_i[d];
            sr      = bus_if.rst_sys_req_i[d];
            prev_on = (lc_run[d] >= SAT);
            if ((lr && lc_run[d] > 0) || (!lr && sr && sys_run[d] > 0)) cap = 1'b1;
            if (lr && !sr) err_m = 1'b1;
            sys_run[d] = (!lr && !sr && prev_on) ? sat_inc(sys_run[d]) : 0;
            lc_run[d]  = lr ? 0 : sat_inc(lc_run[d]);
        end
        bits = 3'b000;
        if (bus_if.reset_cause_i == LowPwrEntry) bits = 3'b001;
        if (bus_if.reset_cause_i == HwReq)       bits = {bus_if.rstreqs_i, 1'b0};
        if (cap && bits != 3'b000) info_m = info_m | bits;
        else if (bus_if.info_clr_i) info_m = 3'b000;
    endtask

    task automatic check_all();
        logic [1:0] exp_lc, exp_sys;
        logic [2:0] exp_info;
        for (int d = 0; d < ND; d++) begin
            exp_lc[d]  = (lc_run[d] >= SAT);
            exp_sys[d] = (sys_run[d] >= SAT);
        end
`ifdef RSTMGR_PWR_RESP_INFO_EN
        exp_info = info_m;
`else
        exp_info = 3'b000;
`endif
        chk("lc_src_n",  32'(bus_if.rst_lc_src_no),    32'(exp_lc));
        chk("sys_src_n", 32'(bus_if.rst_sys_src_no),   32'(exp_sys));
        chk("err",       32'(bus_if.err_o),            32'(err_m));
        chk("info",      32'(bus_if.reset_info_o),     32'(exp_info));
        chk("info_vld",  32'(bus_if.reset_info_vld_o), 32'(exp_info != 3'b000));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_clr();
        bus_if.info_clr_i = 1'b1;
        tick();
        bus_if.info_clr_i = 1'b0;
    endtask

    task automatic random_phase(int segs, logic no_err);
        logic [1:0] lc, sys;
        int hold;
        for (int s = 0; s < segs; s++) begin
            lc   = 2'($urandom_range(0, 3));
            sys  = 2'($urandom_range(0, 3));
            if (no_err) sys = sys | lc;
            hold = $urandom_range(1, 22);
            bus_if.rst_lc_req_i  = lc;
            bus_if.rst_sys_req_i = sys;
            bus_if.reset_cause_i = reset_cause_e'($urandom_range(0, 3));
            bus_if.rstreqs_i     = 2'($urandom_range(0, 3));
            for (int c = 0; c < hold; c++) begin
                bus_if.info_clr_i = ($urandom_range(0, 7) == 0);
                tick();
            end
            bus_if.info_clr_i = 1'b0;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus_if.rst_lc_req_i  = 2'b11;
        bus_if.rst_sys_req_i = 2'b11;
        bus_if.reset_cause_i = ResetNone;
        bus_if.rstreqs_i     = 2'b00;
        bus_if.info_clr_i    = 1'b0;
        model_reset();

        tick();
        tick();
        chk("reset_lc",  32'(bus_if.rst_lc_src_no),  32'(2'b00));
        chk("reset_sys", 32'(bus_if.rst_sys_src_no), 32'(2'b00));
        chk("reset_err", 32'(bus_if.err_o),          32'(1'b0));
        rst_n = 1'b1;
        tick();
        tick();

        // Release from reset: LC then SYS, each stretched.
        bus_if.rst_lc_req_i = 2'b00;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t1_lc_hold", 32'(bus_if.rst_lc_src_no), 32'(2'b00));
        end
        tick();
        chk("t1_lc_rel",  32'(bus_if.rst_lc_src_no),  32'(2'b11));
        chk("t1_sys_low", 32'(bus_if.rst_sys_src_no), 32'(2'b00));
        for (int i = 0; i < 11; i++) tick();
        bus_if.rst_sys_req_i = 2'b00;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t1_sys_hold", 32'(bus_if.rst_sys_src_no), 32'(2'b00));
        end
        tick();
        chk("t1_sys_rel", 32'(bus_if.rst_sys_src_no), 32'(2'b11));

        // Low-power assertion of domain 1 only.
        bus_if.reset_cause_i = LowPwrEntry;
        bus_if.rst_lc_req_i  = 2'b10;
        bus_if.rst_sys_req_i = 2'b10;
        tick();
        chk("t2_lc",  32'(bus_if.rst_lc_src_no),  32'(2'b01));
        chk("t2_sys", 32'(bus_if.rst_sys_src_no), 32'(2'b01));
`ifdef RSTMGR_PWR_RESP_INFO_EN
        chk("t2_info", 32'(bus_if.reset_info_o),     32'(3'b001));
        chk("t2_vld",  32'(bus_if.reset_info_vld_o), 32'(1'b1));
`endif
        bus_if.reset_cause_i = ResetNone;

        // Abort a domain-0 count by re-requesting.
        bus_if.rst_lc_req_i  = 2'b11;
        bus_if.rst_sys_req_i = 2'b11;
        tick();
        tick();
        bus_if.rst_lc_req_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_abort_hold", 32'(bus_if.rst_lc_src_no[0]), 32'(1'b0));
        end
        bus_if.rst_lc_req_i = 2'b11;
        tick();
        tick();
        chk("t3_abort_low", 32'(bus_if.rst_lc_src_no[0]), 32'(1'b0));
        bus_if.rst_lc_req_i = 2'b10;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t3_restart_hold", 32'(bus_if.rst_lc_src_no[0]), 32'(1'b0));
        end
        tick();
        chk("t3_restart_rel", 32'(bus_if.rst_lc_src_no[0]), 32'(1'b1));

        // HwReq capture, then clear.
        pulse_clr();
        bus_if.reset_cause_i = HwReq;
        bus_if.rstreqs_i     = 2'b10;
        bus_if.rst_lc_req_i  = 2'b11;
        bus_if.rst_sys_req_i = 2'b11;
        tick();
`ifdef RSTMGR_PWR_RESP_INFO_EN
        chk("t5_info", 32'(bus_if.reset_info_o), 32'(3'b100));
`else
        chk("t5_info_off", 32'(bus_if.reset_info_o), 32'(3'b000));
`endif
        bus_if.reset_cause_i = ResetNone;
        pulse_clr();
        chk("t5_clr_info", 32'(bus_if.reset_info_o),     32'(3'b000));
        chk("t5_clr_vld",  32'(bus_if.reset_info_vld_o), 32'(1'b0));

        random_phase(30, 1'b1);
        chk("rand_no_err", 32'(bus_if.err_o), 32'(1'b0));

        // Protocol error on domain 1.
        bus_if.rst_lc_req_i  = 2'b11;
        bus_if.rst_sys_req_i = 2'b11;
        tick();
        tick();
        bus_if.rst_sys_req_i = 2'b01;
        tick();
        chk("t4_err",     32'(bus_if.err_o),             32'(1'b1));
        chk("t4_sys_low", 32'(bus_if.rst_sys_src_no[1]), 32'(1'b0));
        bus_if.rst_sys_req_i = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        chk("t4_err_sticky", 32'(bus_if.err_o), 32'(1'b1));

        random_phase(30, 1'b0);

        // Async reset during SysRelWait.
        bus_if.rst_lc_req_i  = 2'b00;
        bus_if.rst_sys_req_i = 2'b00;
        for (int i = 0; i < 2 * SAT + 3; i++) tick();
        bus_if.rst_lc_req_i  = 2'b11;
        bus_if.rst_sys_req_i = 2'b11;
        tick();
        bus_if.rst_lc_req_i  = 2'b00;
        bus_if.rst_sys_req_i = 2'b00;
        for (int i = 0; i < SAT + 2; i++) tick();
        chk("t6_pre_lc", 32'(bus_if.rst_lc_src_no), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        chk("t6_async_lc",  32'(bus_if.rst_lc_src_no),  32'(2'b00));
        chk("t6_async_sys", 32'(bus_if.rst_sys_src_no), 32'(2'b00));
        chk("t6_async_err", 32'(bus_if.err_o),          32'(1'b0));
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t6_lc_hold", 32'(bus_if.rst_lc_src_no), 32'(2'b00));
        end
        tick();
        chk("t6_lc_rel", 32'(bus_if.rst_lc_src_no), 32'(2'b11));
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t6_sys_hold", 32'(bus_if.rst_sys_src_no), 32'(2'b00));
        end
        tick();
        chk("t6_sys_rel", 32'(bus_if.rst_sys_src_no), 32'(2'b11));

        random_phase(20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
